wb_index: RTL and testbench

Write-back index generator: the write-side counterpart of the read-side index unit. Issue pushes a per-instruction write descriptor (base, window, pitch, length, slice, masked, mask); result beats returning from the execution pipeline are matched in order to queued descriptors. Each beat gets a register-file write index and enable, delivered one cycle later to the register-file write port.

---
 rtl/pkg_tpu.sv | 35 +++
 rtl/wb_cfg_fifo.sv | 64 ++++++
 rtl/wb_index.sv | 164 ++++++++++++++++
 tb/tb_wb_index.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_tpu.sv
// pkg_tpu: shared types for the TPU index units.
//   index_t    register-file index
//   mask_t     per-beat write mask
//   wb_cfg_t   write-back descriptor pushed at issue time
//   wb_state_t write-back sequencer state
//   wb_addr()  base + row*pitch + col, wrapping modulo 2^WIDTH_INDEX
package pkg_tpu;

    localparam int WIDTH_INDEX = 8;
    localparam int WIDTH_MASK  = 16;

    typedef logic [WIDTH_INDEX-1:0] index_t;
    typedef logic [WIDTH_MASK-1:0]  mask_t;

    typedef struct packed {
        index_t base;
        index_t window;
        index_t pitch;
        index_t length;
        logic   slice;
        logic   masked;
        mask_t  mask;
    } wb_cfg_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

    // Evaluated at index_t width, so the result wraps with no saturation.
    function automatic index_t wb_addr(index_t base, index_t row, index_t pitch, index_t col);
        return base + row * pitch + col;
    endfunction

endpackage

// File: rtl/wb_cfg_fifo.sv
// wb_cfg_fifo: synchronous descriptor queue with simultaneous push/pop.
//   clock, reset  single clock, synchronous active-high reset
//   push          push request; push_ok reports whether it was taken
//   push_data     descriptor to store
//   pop           pop the head (caller guarantees non-empty)
//   head          current head descriptor
//   full          registered, set when occupancy equals DEPTH
//   empty         occupancy is zero
//   single        exactly one entry queued
module wb_cfg_fifo
    import pkg_tpu::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  wb_cfg_t push_data,
    output logic    push_ok,
    input  logic    pop,
    output wb_cfg_t head,
    output logic    full,
    output logic    empty,
    output logic    single
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_cfg_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            pop_ok;

    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop);
    assign pop_ok     = pop & ~empty;
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);

    assign empty  = (count == '0);
    assign single = (count == CW'(1));
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_index.sv
// wb_index: write-back index generator. Issue pushes write descriptors;
// returning result beats are matched in order and each accepted beat
// produces a register-file write (index, enable, data, last) one cycle later.
//   clock, reset       single clock, synchronous active-high reset
//   I_Stall            blocks beat acceptance and freezes the sequencer
//   I_Cfg_*            descriptor push; O_Cfg_Full is the registered full flag
//   I_Valid, I_Data    result beat; taken when I_Valid & O_Ready
//   O_Req..O_Last      registered write port, one cycle per accepted beat
//   O_Overflow         sticky protocol error (dropped push / beat with empty
//                      queue), only built with WB_INDEX_OVERFLOW_CHK_EN defined
//
// state | meaning
// IDLE  | no descriptor active; moves to RUN once the queue is non-empty
// RUN   | head descriptor active; beats advance k/col/row
module wb_index
    import pkg_tpu::*;
#(
    parameter int NUM_ENTRY_CFG = 4,
    parameter int WIDTH_DATA    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Stall,
    input  logic                   I_Cfg_Req,
    input  logic [WIDTH_INDEX-1:0] I_Cfg_Base,
    input  logic [WIDTH_INDEX-1:0] I_Cfg_Window,
    input  logic [WIDTH_INDEX-1:0] I_Cfg_Pitch,
    input  logic [WIDTH_INDEX-1:0] I_Cfg_Length,
    input  logic                   I_Cfg_Slice,
    input  logic                   I_Cfg_Masked,
    input  logic [WIDTH_MASK-1:0]  I_Cfg_Mask,
    output logic                   O_Cfg_Full,
    input  logic                   I_Valid,
    input  logic [WIDTH_DATA-1:0]  I_Data,
    output logic                   O_Ready,
    output logic                   O_Req,
    output logic                   O_We,
    output logic [WIDTH_INDEX-1:0] O_Index,
    output logic [WIDTH_DATA-1:0]  O_Data,
    output logic                   O_Last,
    output logic                   O_Overflow
);

    wb_cfg_t   cfg_in;
    wb_cfg_t   cur;
    wb_state_t state;
    index_t    k;
    index_t    col;
    index_t    row;
    index_t    eff_len;
    logic      push_ok;
    logic      q_empty;
    logic      q_single;
    logic      accept;
    logic      is_last;
    logic      pop;
    logic      we_beat;
    logic [$clog2(WIDTH_MASK)-1:0] k_lo;

    assign cfg_in = '{base:   I_Cfg_Base,
                      window: I_Cfg_Window,
                      pitch:  I_Cfg_Pitch,
                      length: I_Cfg_Length,
                      slice:  I_Cfg_Slice,
                      masked: I_Cfg_Masked,
                      mask:   I_Cfg_Mask};

    // The active descriptor is read straight from the queue head: it stays
    // queued until its last beat pops it, so the next head is visible in
    // the following cycle and RUN->RUN needs no separate reload path.
    wb_cfg_fifo #(.DEPTH(NUM_ENTRY_CFG)) u_cfg_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (I_Cfg_Req),
        .push_data (cfg_in),
        .push_ok   (push_ok),
        .pop       (pop),
        .head      (cur),
        .full      (O_Cfg_Full),
        .empty     (q_empty),
        .single    (q_single)
    );

    assign O_Ready = ~q_empty & ~I_Stall & (state == RUN);
    assign accept  = I_Valid & O_Ready;
    assign eff_len = cur.slice ? cur.length : '0;
    assign is_last = (k == eff_len);
    assign pop     = accept & is_last;

    // Beats past the mask width are always written.
    assign k_lo    = k[$clog2(WIDTH_MASK)-1:0];
    assign we_beat = ~cur.masked | ((k < index_t'(WIDTH_MASK)) ? cur.mask[k_lo] : 1'b1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            col     <= '0;
            row     <= '0;
            O_Req   <= 1'b0;
            O_We    <= 1'b0;
            O_Index <= '0;
            O_Data  <= '0;
            O_Last  <= 1'b0;
        end else begin
            O_Req   <= accept;
            O_We    <= accept & we_beat;
            O_Index <= accept ? wb_addr(cur.base, row, cur.pitch, col) : '0;
            O_Data  <= accept ? I_Data : '0;
            O_Last  <= accept & is_last;

            unique case (state)
                IDLE: begin
                    if (!q_empty) begin
                        state <= RUN;
                        k     <= '0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (is_last) begin
                            k   <= '0;
                            col <= '0;
                            row <= '0;
                            // Stay in RUN when another descriptor remains,
                            // including one pushed in this same cycle.
                            if (q_single && !push_ok) state <= IDLE;
                        end else begin
                            k <= k + 1'b1;
                            if (col == cur.window) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INDEX_OVERFLOW_CHK_EN
    logic drop;
    logic underflow;

    assign drop      = I_Cfg_Req & ~push_ok;
    assign underflow = I_Valid & ~I_Stall & q_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            O_Overflow <= 1'b0;
        end else if (drop || underflow) begin
            O_Overflow <= 1'b1;
        end
    end
`else
    assign O_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wb_index.sv
module tb_wb_index;
    import pkg_tpu::*;

    localparam int N  = 4;
    localparam int WD = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_Stall;
    logic          I_Cfg_Req;
    logic [7:0]    I_Cfg_Base, I_Cfg_Window, I_Cfg_Pitch, I_Cfg_Length;
    logic          I_Cfg_Slice, I_Cfg_Masked;
    logic [15:0]   I_Cfg_Mask;
    logic          O_Cfg_Full;
    logic          I_Valid;
    logic [WD-1:0] I_Data;
    logic          O_Ready, O_Req, O_We, O_Last, O_Overflow;
    logic [7:0]    O_Index;
    logic [WD-1:0] O_Data;

    always #5 clock = ~clock;

    wb_index #(.NUM_ENTRY_CFG(N), .WIDTH_DATA(WD)) dut (
        .clock(clock), .reset(reset), .I_Stall(I_Stall),
        .I_Cfg_Req(I_Cfg_Req), .I_Cfg_Base(I_Cfg_Base), .I_Cfg_Window(I_Cfg_Window),
        .I_Cfg_Pitch(I_Cfg_Pitch), .I_Cfg_Length(I_Cfg_Length), .I_Cfg_Slice(I_Cfg_Slice),
        .I_Cfg_Masked(I_Cfg_Masked), .I_Cfg_Mask(I_Cfg_Mask), .O_Cfg_Full(O_Cfg_Full),
        .I_Valid(I_Valid), .I_Data(I_Data), .O_Ready(O_Ready), .O_Req(O_Req),
        .O_We(O_We), .O_Index(O_Index), .O_Data(O_Data), .O_Last(O_Last),
        .O_Overflow(O_Overflow)
    );

    typedef struct {
        int          tag;
        logic [7:0]  idx;
        logic        we;
        logic        last;
        logic [31:0] data;
    } beat_t;

    wb_cfg_t mq[$];
    beat_t   sb[$];
    int      head_pos = 0;
    bit      run_m = 0;
    bit      ovf_m = 0;
    bit      mon_en = 0;
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference rules: beat n of a descriptor sits at column n mod (window+1)
    // of row n div (window+1).
    function automatic int nbeats(wb_cfg_t c);
        return c.slice ? int'(c.length) + 1 : 1;
    endfunction

    function automatic logic [7:0] beat_index(wb_cfg_t c, int n);
        int w, v;
        w = int'(c.window) + 1;
        v = (int'(c.base) + (n / w) * int'(c.pitch) + (n % w)) % 256;
        return v[7:0];
    endfunction

    function automatic logic beat_we(wb_cfg_t c, int n);
        if (!c.masked) return 1'b1;
        if (n >= 16) return 1'b1;
        return c.mask[n];
    endfunction

    function automatic wb_cfg_t mk(int base, int window, int pitch, int length,
                                   bit slice, bit masked, int mask);
        wb_cfg_t c;
        c.base   = base[7:0];
        c.window = window[7:0];
        c.pitch  = pitch[7:0];
        c.length = length[7:0];
        c.slice  = slice;
        c.masked = masked;
        c.mask   = mask[15:0];
        return c;
    endfunction

    function automatic wb_cfg_t rand_cfg();
        return mk($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 24), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 65535));
    endfunction

    // One clock cycle: drive inputs, advance the reference model, compare
    // the combinational/registered status outputs mid-cycle.
    task automatic step(bit rst, bit stall, bit valid, logic [31:0] data, bit req, wb_cfg_t c);
        bit exp_ready, exp_full, exp_ovf, acc, lastb, popd, nxt_run;
        int size0;
        @(posedge clock);
        #1;
        cyc++;
        reset        = rst;
        I_Stall      = stall;
        I_Valid      = valid;
        I_Data       = data;
        I_Cfg_Req    = req;
        I_Cfg_Base   = c.base;
        I_Cfg_Window = c.window;
        I_Cfg_Pitch  = c.pitch;
        I_Cfg_Length = c.length;
        I_Cfg_Slice  = c.slice;
        I_Cfg_Masked = c.masked;
        I_Cfg_Mask   = c.mask;

        size0     = mq.size();
        exp_ready = run_m && size0 > 0 && !stall;
        exp_full  = (size0 == N);
        exp_ovf   = ovf_m;
        acc       = valid && exp_ready && !rst;

        if (rst) begin
            mq.delete();
            head_pos = 0;
            run_m    = 0;
            ovf_m    = 0;
        end else begin
            popd    = 0;
            nxt_run = run_m ? 1'b1 : (size0 > 0);
            if (acc) begin
                lastb = (head_pos == nbeats(mq[0]) - 1);
                sb.push_back('{cyc, beat_index(mq[0], head_pos), beat_we(mq[0], head_pos),
                               lastb, data});
                if (lastb) popd = 1;
                else head_pos++;
            end
            if (req) begin
                if (size0 < N || popd) mq.push_back(c);
`ifdef WB_INDEX_OVERFLOW_CHK_EN
                else ovf_m = 1;
`endif
            end
            if (popd) begin
                void'(mq.pop_front());
                head_pos = 0;
                if (mq.size() == 0) nxt_run = 0;
            end
`ifdef WB_INDEX_OVERFLOW_CHK_EN
            if (valid && !stall && size0 == 0) ovf_m = 1;
`endif
            run_m = nxt_run;
        end

        @(negedge clock);
        chk("o_ready", O_Ready, exp_ready);
        chk("o_cfg_full", O_Cfg_Full, exp_full);
        chk("o_overflow", O_Overflow, exp_ovf);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    task automatic push(wb_cfg_t c);
        step(0, 0, 0, '0, 1, c);
    endtask

    task automatic beats(int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, $urandom, 0, '0);
    endtask

    // Monitor: write-port beats are matched against the scoreboard, tagged
    // with the cycle they were accepted in (they must appear one cycle later).
    always @(negedge clock) begin
        beat_t b;
        bit    exp_req;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].tag < cyc - 1) void'(sb.pop_front());
            exp_req = (sb.size() > 0 && sb[0].tag == cyc - 1);
            chk("o_req", O_Req, exp_req);
            if (O_Req && exp_req) begin
                b = sb.pop_front();
                chk("o_index", O_Index, b.idx);
                chk("o_we", O_We, b.we);
                chk("o_last", O_Last, b.last);
                chk("o_data", O_Data, b.data);
            end else if (!O_Req) begin
                chk("idle_outputs_zero", {O_We, O_Last, O_Index, O_Data}, '0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; I_Stall = 0; I_Cfg_Req = 0; I_Valid = 0; I_Data = '0;
        I_Cfg_Base = '0; I_Cfg_Window = '0; I_Cfg_Pitch = '0; I_Cfg_Length = '0;
        I_Cfg_Slice = 0; I_Cfg_Masked = 0; I_Cfg_Mask = '0;
        repeat (2) @(posedge clock);
        #1;
        mon_en = 1;

        // single-beat descriptor
        push(mk(8'h10, 0, 0, 7, 0, 0, 0));
        idle(1);
        step(0, 0, 1, 32'hA5, 0, '0);
        idle(2);

        // 2-D slice: 0x20,0x21,0x28,0x29,0x30,0x31
        push(mk(8'h20, 1, 8, 5, 1, 0, 0));
        idle(1);
        beats(6);
        idle(2);

        // masked slice: we = 1,0,1,0
        push(mk(8'h40, 3, 1, 3, 1, 1, 16'h0005));
        idle(1);
        beats(4);
        idle(2);

        // back-to-back descriptors, continuous beats
        push(mk(8'h50, 0, 4, 2, 1, 0, 0));
        push(mk(8'hF0, 2, 16, 3, 1, 1, 16'h000A));
        beats(7);
        idle(2);

        // stall mid-slice
        push(mk(8'h60, 1, 2, 7, 1, 0, 0));
        idle(1);
        beats(3);
        for (int i = 0; i < 3; i++) step(0, 1, 1, $urandom, 0, '0);
        beats(5);
        idle(2);

        // full queue, extra push dropped
        for (int i = 0; i < 4; i++) push(mk(8'h70 + i, 0, 0, 0, 0, 0, 0));
        push(mk(8'h99, 0, 0, 0, 0, 0, 0));
        idle(2);
        beats(4);
        idle(2);

        // reset mid-slice and with a full queue
        push(mk(8'h80, 2, 5, 9, 1, 1, 16'hFFF0));
        idle(1);
        beats(3);
        step(1, 0, 0, '0, 0, '0);
        idle(2);
        for (int i = 0; i < 4; i++) push(rand_cfg());
        step(1, 0, 0, '0, 0, '0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0)
                step(1, 0, 0, '0, 0, '0);
            else
                step(0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, $urandom,
                     $urandom_range(0, 9) < 3, rand_cfg());
        end
        idle(4);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
